// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between two requesters, the write-port arbiter and the register file.
// The master side is the requester/observer; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
   parameter int unsigned p_data_nbits  = 32,
   parameter int unsigned p_num_entries = 32
);
   localparam int unsigned c_addr_nbits = $clog2(p_num_entries);

   logic                    req0_val;
   logic                    req0_rdy;
   logic [c_addr_nbits-1:0] req0_addr;
   logic [p_data_nbits-1:0] req0_data;
   logic                    req1_val;
   logic                    req1_rdy;
   logic [c_addr_nbits-1:0] req1_addr;
   logic [p_data_nbits-1:0] req1_data;
   logic                    rf_write_en;
   logic [c_addr_nbits-1:0] rf_write_addr;
   logic [p_data_nbits-1:0] rf_write_data;
   logic                    init_done;

   modport master (
      output req0_val, req0_addr, req0_data,
      output req1_val, req1_addr, req1_data,
      input  req0_rdy, req1_rdy,
      input  rf_write_en, rf_write_addr, rf_write_data, init_done
   );

   modport slave (
      input  req0_val, req0_addr, req0_data,
      input  req1_val, req1_addr, req1_data,
      output req0_rdy, req1_rdy,
      output rf_write_en, rf_write_addr, rf_write_data, init_done
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Owns the register file write port: clears every entry after reset/clear, then
// round-robin arbitrates two val/rdy requesters with a same-cycle grant.
module regfile_write_arbiter #(
   parameter int unsigned              p_data_nbits  = 32,
   parameter int unsigned              p_num_entries = 32,
   parameter logic [p_data_nbits-1:0]  p_clear_value = '0,
   localparam int unsigned             c_addr_nbits  = $clog2(p_num_entries)
) (
   input logic                    clk,
   input logic                    reset,
   input logic                    clear,
   regfile_write_arbiter_if.slave bus
);

   typedef enum logic {StInit, StRun} state_e;

   state_e                  state_q, state_d;
   logic [c_addr_nbits-1:0] cnt_q, cnt_d;
   logic                    ptr_q, ptr_d;  // 0: req0 wins a tie, 1: req1 wins a tie
   logic                    gnt0, gnt1;

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset && state_q == StRun) begin
         gnt0 = bus.req0_val && (!bus.req1_val || !ptr_q);
         gnt1 = bus.req1_val && (!bus.req0_val ||  ptr_q);
      end
   end

   always_comb begin
      bus.req0_rdy      = gnt0;
      bus.req1_rdy      = gnt1;
      bus.rf_write_en   = 1'b0;
      bus.rf_write_addr = bus.req0_addr;
      bus.rf_write_data = bus.req0_data;
      bus.init_done     = 1'b0;
      if (!reset) begin
         unique case (state_q)
            StInit: begin
               bus.rf_write_en   = 1'b1;
               bus.rf_write_addr = cnt_q;
               bus.rf_write_data = p_clear_value;
            end
            StRun: begin
               bus.init_done   = 1'b1;
               bus.rf_write_en = bus.req0_val | bus.req1_val;
               if (gnt1) begin
                  bus.rf_write_addr = bus.req1_addr;
                  bus.rf_write_data = bus.req1_data;
               end
            end
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StInit: begin
            if (clear) begin
               cnt_d = '0;
            end else if (cnt_q == c_addr_nbits'(p_num_entries - 1)) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + c_addr_nbits'(1);
            end
         end
         StRun: begin
            if (gnt0) ptr_d = 1'b1;
            else if (gnt1) ptr_d = 1'b0;
            // The grant in a clear cycle still writes; only the pointer is forced.
            if (clear) begin
               state_d = StInit;
               cnt_d   = '0;
               ptr_d   = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StInit;
         cnt_q   <= '0;
         ptr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
      end
   end

   a_val0_known: assert property (@(posedge clk) disable iff (reset)
      !$isunknown(bus.req0_val));
   a_val1_known: assert property (@(posedge clk) disable iff (reset)
      !$isunknown(bus.req1_val));
   a_addr0_ok: assert property (@(posedge clk) disable iff (reset)
      bus.req0_val |-> (!$isunknown(bus.req0_addr) && (32'(bus.req0_addr) < p_num_entries)));
   a_addr1_ok: assert property (@(posedge clk) disable iff (reset)
      bus.req1_val |-> (!$isunknown(bus.req1_addr) && (32'(bus.req1_addr) < p_num_entries)));
   a_hold0: assert property (@(posedge clk) disable iff (reset)
      (bus.req0_val && !bus.req0_rdy) |=>
      (bus.req0_val && $stable(bus.req0_addr) && $stable(bus.req0_data)));
   a_hold1: assert property (@(posedge clk) disable iff (reset)
      (bus.req1_val && !bus.req1_rdy) |=>
      (bus.req1_val && $stable(bus.req1_addr) && $stable(bus.req1_data)));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with 4 x 8-bit entries and clear value 0x5A.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_regfile_write_arbiter;

   localparam int unsigned p_data_nbits  = 8;
   localparam int unsigned p_num_entries = 4;
   localparam logic [7:0]  p_clear_value = 8'h5A;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic clear = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] mem [p_num_entries];

   regfile_write_arbiter_if #(
      .p_data_nbits  (p_data_nbits),
      .p_num_entries (p_num_entries)
   ) bus ();

   regfile_write_arbiter #(
      .p_data_nbits  (p_data_nbits),
      .p_num_entries (p_num_entries),
      .p_clear_value (p_clear_value)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Storage array with no reset, written only through the arbiter's port.
   always @(posedge clk) begin
      if (bus.rf_write_en) mem[bus.rf_write_addr] <= bus.rf_write_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic exp_ctl(input string tag, input logic we, input logic r0, input logic r1,
                          input logic done);
      check_eq({tag, "/we"},   32'(bus.rf_write_en), 32'(we));
      check_eq({tag, "/rdy0"}, 32'(bus.req0_rdy),    32'(r0));
      check_eq({tag, "/rdy1"}, 32'(bus.req1_rdy),    32'(r1));
      check_eq({tag, "/done"}, 32'(bus.init_done),   32'(done));
   endtask

   task automatic exp_out(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic r0, input logic r1,
                          input logic done);
      exp_ctl(tag, we, r0, r1, done);
      check_eq({tag, "/addr"}, 32'(bus.rf_write_addr), addr);
      check_eq({tag, "/data"}, 32'(bus.rf_write_data), data);
   endtask

   task automatic set_req(input logic v0, input logic [31:0] a0, input logic [31:0] d0,
                          input logic v1, input logic [31:0] a1, input logic [31:0] d1);
      bus.req0_val  = v0;
      bus.req0_addr = 2'(a0);
      bus.req0_data = 8'(d0);
      bus.req1_val  = v1;
      bus.req1_addr = 2'(a1);
      bus.req1_data = 8'(d1);
   endtask

   // Called already positioned on the first sweep cycle.
   task automatic expect_sweep(input string tag);
      for (int i = 0; i < int'(p_num_entries); i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         exp_out(tag, 1'b1, 32'(i), 32'h5A, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      #1;
      check_eq({tag, "/done_after"}, 32'(bus.init_done), 32'd1);
      for (int i = 0; i < int'(p_num_entries); i++) begin
         check_eq({tag, "/mem"}, 32'(mem[i]), 32'h5A);
      end
   endtask

   initial begin
      set_req(0, 0, 0, 0, 0, 0);

      // 1: reset for two edges, then the sweep.
      @(negedge clk);
      #1;
      exp_ctl("rst1", 0, 0, 0, 0);
      @(negedge clk);
      #1;
      exp_ctl("rst2", 0, 0, 0, 0);
      reset = 1'b0;
      #1;
      expect_sweep("init");

      // 2: single req0 write, read back next cycle.
      @(negedge clk);
      set_req(1, 2, 'hAB, 0, 0, 0);
      #1;
      exp_out("t2", 1, 2, 'hAB, 1, 0, 1);
      @(negedge clk);
      set_req(0, 0, 0, 1, 0, 'h33);
      #1;
      check_eq("t2_rd", 32'(mem[2]), 'hAB);
      exp_out("pre3", 1, 0, 'h33, 0, 1, 1);

      // 3: both valid, grants alternate starting with req0.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         set_req(1, 3, 'h11, 1, 1, 'h22);
         #1;
         if (k % 2 == 0) exp_out("t3", 1, 3, 'h11, 1, 0, 1);
         else            exp_out("t3", 1, 1, 'h22, 0, 1, 1);
      end
      @(negedge clk);
      set_req(1, 3, 'h11, 0, 1, 'h22);
      #1;
      exp_out("t3tail", 1, 3, 'h11, 1, 0, 1);

      // 4: req1 alone transfers, then req0 wins the tie.
      @(negedge clk);
      set_req(0, 3, 'h11, 1, 0, 'h33);
      #1;
      exp_out("t4a", 1, 0, 'h33, 0, 1, 1);
      @(negedge clk);
      set_req(1, 3, 'h11, 1, 1, 'h22);
      #1;
      exp_out("t4b", 1, 3, 'h11, 1, 0, 1);
      @(negedge clk);
      set_req(0, 3, 'h11, 1, 1, 'h22);
      #1;
      exp_out("t4c", 1, 1, 'h22, 0, 1, 1);
      @(negedge clk);
      set_req(0, 1, 'h77, 0, 2, 'h99);
      #1;
      exp_out("idle", 0, 1, 'h77, 0, 0, 1);

      // 5: clear in RUN while req0 writes; pointer returns to req0.
      @(negedge clk);
      set_req(1, 2, 'h44, 0, 0, 0);
      clear = 1'b1;
      #1;
      exp_out("t5clr", 1, 2, 'h44, 1, 0, 1);
      @(negedge clk);
      clear = 1'b0;
      set_req(0, 0, 0, 0, 0, 0);
      #1;
      check_eq("t5_rd", 32'(mem[2]), 'h44);
      expect_sweep("t5sw");
      @(negedge clk);
      set_req(1, 3, 'h11, 1, 1, 'h22);
      #1;
      exp_out("t5win", 1, 3, 'h11, 1, 0, 1);
      @(negedge clk);
      set_req(0, 3, 'h11, 1, 1, 'h22);
      #1;
      exp_out("t5tail", 1, 1, 'h22, 0, 1, 1);

      // 6: reset when the sweep counter reaches 2.
      @(negedge clk);
      set_req(0, 0, 0, 0, 0, 0);
      clear = 1'b1;
      #1;
      exp_out("t6clr", 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      clear = 1'b0;
      #1;
      exp_out("t6s0", 1, 0, 'h5A, 0, 0, 0);
      @(negedge clk);
      #1;
      exp_out("t6s1", 1, 1, 'h5A, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      exp_ctl("t6rst", 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      expect_sweep("t6sw");

      // 7: clear during the sweep restarts the counter.
      @(negedge clk);
      clear = 1'b1;
      #1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      exp_out("t7s0", 1, 0, 'h5A, 0, 0, 0);
      @(negedge clk);
      clear = 1'b1;
      #1;
      exp_out("t7s1", 1, 1, 'h5A, 0, 0, 0);
      @(negedge clk);
      clear = 1'b0;
      #1;
      expect_sweep("t7sw");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
